// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steps the PC through a combinational instruction ROM and
// queues {PC, instruction} pairs in a small FIFO for the decode/rename stage.
// A redirect flushes the queue and restarts fetch. Fetch halts when the PC
// leaves the ROM address range.
module fetch_sequencer #(
    parameter int          DEPTH    = 4,
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [63:0]                  imem_addr,
    input  logic [31:0]                  imem_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [63:0]                  out_pc,
    input  logic                         redirect_valid,
    input  logic [63:0]                  redirect_pc,
    output logic                         halted,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          state_q;
    logic            halted_q;
    logic [63:0]     pc_q;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [63:0]     buf_pc_q    [DEPTH];
    logic [31:0]     buf_instr_q [DEPTH];

    logic            pop;
    logic            push;
    logic            oob;
    logic [63:0]     redirect_pc_d;
    logic            unused_redirect_lsbs;

    // The low two bits of a redirect target are dropped to keep fetch word-aligned.
    assign redirect_pc_d        = {redirect_pc[63:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign oob       = (pc_q + 64'd3) >= 64'(MEM_SIZE);
    // A full buffer can still accept a word when the head leaves the same cycle.
    assign push      = (state_q == ST_RUN) & ~oob & ~redirect_valid &
                       ((count_q < CW'(DEPTH)) | pop);

    assign imem_addr = pc_q;
    assign out_instr = buf_instr_q[head_q];
    assign out_pc    = buf_pc_q[head_q];
    assign halted    = halted_q;
    assign count     = count_q;

    // Control FSM: PC, pointers, occupancy and RUN/HALT state; redirect wins over everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            pc_q     <= RESET_PC;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            pc_q     <= redirect_pc_d;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + 1'b1;
                pc_q   <= pc_q + 64'd4;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            if (state_q == ST_RUN && oob) begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
            end
        end
    end

    // One storage slot per buffer entry, written when it is the tail of a push.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    buf_pc_q[gi]    <= '0;
                    buf_instr_q[gi] <= '0;
                end else if (push && (tail_q == PW'(gi))) begin
                    buf_pc_q[gi]    <= pc_q;
                    buf_instr_q[gi] <= imem_instr;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed phases push the expected PCs
// of each delivered instruction; a negedge monitor compares every handshake.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halted;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb[$];
    logic [31:0] rom [256];

    always #5 clk = ~clk;

    fetch_sequencer #(.DEPTH(4), .MEM_SIZE(1024), .RESET_PC(64'd0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .count          (count)
    );

    function automatic logic [31:0] exp_instr(input logic [63:0] pc);
        return {8'hC3, pc[9:2], ~pc[9:2], pc[9:2]};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {8'hC3, i[7:0], ~i[7:0], i[7:0]};
    end
    assign imem_instr = rom[imem_addr[9:2]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [63:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(start + 64'(4 * i));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_addr", imem_addr, 64'd0);
        sb.delete();
        tick();
        reset = 1'b1;
    endtask

    // Monitor: every accepted head must match the next expected PC/instruction.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=pc 0x%0h required=no pop", out_pc);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("sb_pc", out_pc, e);
                check("sb_instr", 64'(out_instr), 64'(exp_instr(e)));
            end
        end
    end

    initial begin
        reset = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_pc", out_pc, 64'd0);
        check("rst_addr", imem_addr, 64'd0);
        tick();

        // Streaming with out_ready=1: one instruction per cycle, count stays 1.
        reset = 1'b1;
        out_ready = 1'b1;
        push_range(64'd0, 8);
        tick();
        repeat (8) begin
            check("stream_count", 64'(count), 64'd1);
            tick();
        end
        out_ready = 1'b0;
        check("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure: buffer fills to DEPTH, PC stops at 16.
        do_reset();
        repeat (10) tick();
        check("full_count", 64'(count), 64'd4);
        check("full_addr", imem_addr, 64'd16);
        check("full_head", out_pc, 64'd0);

        // Full buffer with simultaneous push/pop.
        push_range(64'd0, 6);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("pp_count", 64'(count), 64'd4);
            check("pp_addr", imem_addr, 64'(16 + 4 * k));
            tick();
        end
        out_ready = 1'b0;
        check("pp_sb_empty", 64'(sb.size()), 64'd0);

        // Redirect to 0x42 with count=3 and a same-cycle pop.
        do_reset();
        repeat (3) tick();
        check("rd_pre_count", 64'(count), 64'd3);
        sb.push_back(64'd0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h42;
        out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        check("rd_count", 64'(count), 64'd0);
        check("rd_valid", 64'(out_valid), 64'd0);
        check("rd_addr", imem_addr, 64'h40);
        tick();
        check("rd_first_valid", 64'(out_valid), 64'd1);
        check("rd_first_pc", out_pc, 64'h40);
        push_range(64'h40, 3);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        check("rd_sb_empty", 64'(sb.size()), 64'd0);

        // Back-to-back redirects: the second one wins.
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        tick();
        redirect_pc = 64'h200;
        tick();
        redirect_valid = 1'b0;
        check("b2b_addr", imem_addr, 64'h200);
        check("b2b_count", 64'(count), 64'd0);
        tick();
        check("b2b_pc", out_pc, 64'h200);
        check("b2b_instr", 64'(out_instr), 64'(exp_instr(64'h200)));

        // End of ROM: last push at 1020, then HALT with the buffer draining.
        redirect_valid = 1'b1;
        redirect_pc = 64'd1012;
        tick();
        redirect_valid = 1'b0;
        repeat (5) tick();
        check("eor_halted", 64'(halted), 64'd1);
        check("eor_addr", imem_addr, 64'd1024);
        check("eor_count", 64'(count), 64'd3);
        push_range(64'd1012, 3);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        check("drain_count", 64'(count), 64'd0);
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_halted", 64'(halted), 64'd1);
        check("drain_addr", imem_addr, 64'd1024);
        check("drain_sb_empty", 64'(sb.size()), 64'd0);

        // Redirect out of HALT resumes fetch.
        redirect_valid = 1'b1;
        redirect_pc = 64'd0;
        tick();
        redirect_valid = 1'b0;
        check("resume_halted", 64'(halted), 64'd0);
        check("resume_addr", imem_addr, 64'd0);
        tick();
        check("resume_valid", 64'(out_valid), 64'd1);
        check("resume_pc", out_pc, 64'd0);
        check("resume_instr", 64'(out_instr), 64'(exp_instr(64'd0)));
        check("resume_count", 64'(count), 64'd1);

        // Redirect to an out-of-bounds PC: RUN for one edge, then HALT.
        redirect_valid = 1'b1;
        redirect_pc = 64'h1000;
        tick();
        redirect_valid = 1'b0;
        check("oobrd_halted0", 64'(halted), 64'd0);
        check("oobrd_addr", imem_addr, 64'h1000);
        tick();
        check("oobrd_halted1", 64'(halted), 64'd1);
        check("oobrd_count", 64'(count), 64'd0);
        check("oobrd_addr_hold", imem_addr, 64'h1000);

        // Asynchronous reset mid-stream with count=2.
        redirect_valid = 1'b1;
        redirect_pc = 64'd0;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("mid_pre_count", 64'(count), 64'd2);
        check("mid_pre_addr", imem_addr, 64'd8);
        #3;
        reset = 1'b0;
        #1;
        check("mid_valid", 64'(out_valid), 64'd0);
        check("mid_count", 64'(count), 64'd0);
        check("mid_addr", imem_addr, 64'd0);
        check("mid_pc", out_pc, 64'd0);
        tick();
        reset = 1'b1;
        check("mid_hold_count", 64'(count), 64'd0);
        tick();
        check("mid_restart_valid", 64'(out_valid), 64'd1);
        check("mid_restart_pc", out_pc, 64'd0);
        check("mid_restart_count", 64'(count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
